// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_TURN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port,
// round-robin on ties, one access per two cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_wdone,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  output logic        mem_wren,
  input  logic [31:0] mem_rdata
);

  arb_state_t state_q, state_d;
  owner_t     last_owner_q, last_owner_d;
  owner_t     owner_q, owner_d;

  logic pick_inst, pick_data;

  // Fetch wins unless data is also pending and fetch was the last owner.
  assign pick_inst = (state_q == IDLE) && i_req &&
                     (!d_req || (last_owner_q == OWN_DATA));
  assign pick_data = (state_q == IDLE) && d_req && !pick_inst;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_DATA;
      owner_q      <= OWN_INST;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_inst) begin
          state_d      = READ_WAIT;
          owner_d      = OWN_INST;
          last_owner_d = OWN_INST;
        end else if (pick_data) begin
          state_d      = d_we ? WRITE_TURN : READ_WAIT;
          owner_d      = OWN_DATA;
          last_owner_d = OWN_DATA;
        end
      end
      READ_WAIT:  state_d = IDLE;
      WRITE_TURN: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr   = i_addr;
    mem_wdata  = d_wdata;
    mem_funct3 = FETCH_FUNCT3;
    mem_wren   = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    d_wdone    = 1'b0;
    i_rdata    = mem_rdata;
    d_rdata    = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (pick_inst) begin
          i_gnt = 1'b1;
        end else if (pick_data) begin
          d_gnt      = 1'b1;
          mem_addr   = d_addr;
          mem_funct3 = d_funct3;
          mem_wren   = d_we;
        end
      end
      READ_WAIT: begin
        i_rvalid = (owner_q == OWN_INST);
        d_rvalid = (owner_q == OWN_DATA);
      end
      WRITE_TURN: d_wdone = 1'b1;
      default: ;
    endcase
    // Reset masks all handshakes immediately, before the state flops clear.
    if (!reset) begin
      mem_wren = 1'b0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      d_wdone  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt, d_rvalid, d_wdone;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_wren;
  logic [31:0] mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wdone(d_wdone), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  // Handshake vector: {i_gnt, d_gnt, mem_wren, i_rvalid, d_rvalid, d_wdone}
  logic [5:0] hs;
  assign hs = {i_gnt, d_gnt, mem_wren, i_rvalid, d_rvalid, d_wdone};

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    #1;
    n_cmp++;
    if (hs !== 6'b000000) begin
      n_err++; $display("FAIL reset_mask: got %b want 000000", hs);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    n_cmp++;
    if (hs !== 6'b000000 || mem_addr !== i_addr) begin
      n_err++; $display("FAIL reset_idle: got hs=%b addr=%h want 000000 addr=%h", hs, mem_addr, i_addr);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    #1;
    n_cmp++;
    if (hs !== 6'b100000 || mem_addr !== 32'h100 || mem_funct3 !== 3'b010) begin
      n_err++; $display("FAIL fetch_issue: got hs=%b addr=%h f3=%b want 100000 100 010", hs, mem_addr, mem_funct3);
    end
    @(negedge clk);
    i_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (hs !== 6'b000100 || i_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL fetch_rvalid: got hs=%b rdata=%h want 000100 deadbeef", hs, i_rdata);
    end
    @(negedge clk);
    i_addr = 32'h555;
    #1;
    n_cmp++;
    if (hs !== 6'b000000 || mem_addr !== 32'h555) begin
      n_err++; $display("FAIL idle_default: got hs=%b addr=%h want 000000 555", hs, mem_addr);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g [7] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = 3'b010;
    for (int k = 0; k < 7; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({i_gnt, d_gnt} !== exp_g[k]) begin
        n_err++; $display("FAIL tie_cycle%0d: got %b want %b", k, {i_gnt, d_gnt}, exp_g[k]);
      end
      if (k == 2) begin
        n_cmp++;
        if (mem_addr !== 32'h200) begin
          n_err++; $display("FAIL tie_daddr: got %h want 200", mem_addr);
        end
      end
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_funct3 = 3'b010;
    #1;
    n_cmp++;
    if (hs !== 6'b011000 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || mem_funct3 !== 3'b010) begin
      n_err++; $display("FAIL store_issue: got hs=%b addr=%h wd=%h f3=%b", hs, mem_addr, mem_wdata, mem_funct3);
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h300;
    #1;
    n_cmp++;
    if (hs !== 6'b000001 || mem_addr !== 32'h300) begin
      n_err++; $display("FAIL store_turn: got hs=%b addr=%h want 000001 300", hs, mem_addr);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (hs !== 6'b100000) begin
      n_err++; $display("FAIL store_waited_fetch: got %b want 100000", hs);
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned gnts = 0;
    int unsigned rvs  = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_funct3 = 3'b000;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      gnts += d_gnt;
      rvs  += d_rvalid;
      n_cmp++;
      if ({d_gnt, d_rvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL b2b_cycle%0d: got %b want %b", k, {d_gnt, d_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    n_cmp++;
    if (gnts != 4 || rvs != 4) begin
      n_err++; $display("FAIL b2b_count: got gnt=%0d rv=%0d want 4 4", gnts, rvs);
    end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    n_cmp++;
    if (i_gnt !== 1'b1) begin
      n_err++; $display("FAIL abort_gnt: got %b want 1", i_gnt);
    end
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0;
    #1;
    n_cmp++;
    if (hs !== 6'b000000) begin
      n_err++; $display("FAIL abort_mask: got %b want 000000", hs);
    end
    @(negedge clk);
    reset = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    #1;
    n_cmp++;
    if (hs !== 6'b010000) begin
      n_err++; $display("FAIL abort_idle: got %b want 010000", hs);
    end
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44;
    #1;
    n_cmp++;
    if (hs !== 6'b011000) begin
      n_err++; $display("FAIL abort_store_issue: got %b want 011000", hs);
    end
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    n_cmp++;
    if (hs !== 6'b000000) begin
      n_err++; $display("FAIL abort_store_mask: got %b want 000000", hs);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (hs !== 6'b000000 || mem_addr !== i_addr) begin
      n_err++; $display("FAIL abort_store_after: got hs=%b addr=%h want 000000 %h", hs, mem_addr, i_addr);
    end
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
    mem_rdata = '0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  always @(negedge clk) begin
    #2;
    if (i_gnt && d_gnt) begin
      n_err++; $display("FAIL dual_gnt: got i_gnt=1 d_gnt=1 want at most one");
    end
  end

endmodule
